// File: rtl/trigger_pkg.sv
// Shared types and default parameters for the multi-channel trigger input sampler.
package trigger_pkg;

    localparam int unsigned NCH_DEF  = 4;
    localparam int unsigned FILT_DEF = 4;
    localparam int unsigned POSW_DEF = 4;
    localparam int unsigned DTW_DEF  = 8;

    typedef enum logic [1:0] {
        CH_IDLE     = 2'd0,
        CH_CAPT     = 2'd1,
        CH_WAIT_LOW = 2'd2,
        CH_DEAD     = 2'd3
    } ch_state_e;

    // Per-channel window status handed to the report registers at stop.
    typedef struct packed {
        logic hit;
        logic lost;
        logic overrun;
    } ch_report_t;

endpackage

// File: rtl/trigger_in_channel.sv
// One trigger line: synchroniser, glitch filter, edge detect, capture FSM and dead-time counter.
module trigger_in_channel
    import trigger_pkg::*;
#(
    parameter int unsigned FILT = FILT_DEF,
    parameter int unsigned POSW = POSW_DEF,
    parameter int unsigned DTW  = DTW_DEF
) (
    input  logic            clk400,
    input  logic            reset,
    input  logic            i_trigger,
    input  logic            i_enable,
    input  logic [DTW-1:0]  i_deadtime,
    input  logic [POSW-1:0] i_poscnt,
    input  logic            i_stop,
    output ch_report_t      o_report_c,
    output logic [POSW-1:0] o_pos
);

    logic [1:0]      r_sync;
    logic [FILT-1:0] r_s;
    logic            r_den;
    logic            r_den_d;

    ch_state_e       r_state;
    ch_state_e       w_state_nxt;
    logic [DTW-1:0]  r_dt;
    logic [DTW-1:0]  w_dt_nxt;
    logic [POSW-1:0] r_pos;
    logic [POSW-1:0] w_pos_nxt;
    logic            r_lost;
    logic            w_lost_nxt;
    logic            w_lost_c;
    logic            r_ovr;
    logic            w_ovr_nxt;
    logic            w_ovr_c;

    logic            w_den_set;
    logic            w_den_clr;
    logic            w_start;
    logic            w_dt_nz;

    assign w_den_set = r_s[FILT-1] & r_s[0] & (|r_s[FILT-2:1]);
    assign w_den_clr = (r_s[FILT-2:0] == '0);
    assign w_start   = r_den & ~r_den_d;
    assign w_dt_nz   = (i_deadtime != '0);

    // Synchroniser and filter; den holds between the set and clear patterns.
    always_ff @(posedge clk400 or posedge reset) begin
        if (reset) begin
            r_sync  <= '0;
            r_s     <= '0;
            r_den   <= 1'b0;
            r_den_d <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_trigger};
            r_s     <= {r_s[FILT-2:0], r_sync[1]};
            if (w_den_set) begin
                r_den <= 1'b1;
            end else if (w_den_clr) begin
                r_den <= 1'b0;
            end
            r_den_d <= r_den;
        end
    end

    always_ff @(posedge clk400 or posedge reset) begin
        if (reset) begin
            r_state <= CH_IDLE;
            r_dt    <= '0;
            r_pos   <= '0;
            r_lost  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dt    <= w_dt_nxt;
            r_pos   <= w_pos_nxt;
            r_lost  <= w_lost_nxt;
            r_ovr   <= w_ovr_nxt;
        end
    end

    // A start coinciding with stop is folded into the window being reported.
    always_comb begin
        w_state_nxt = r_state;
        w_dt_nxt    = r_dt;
        w_pos_nxt   = r_pos;
        w_lost_c    = r_lost | (w_start & (r_state == CH_DEAD));
        w_ovr_c     = r_ovr  | (w_start & (r_state == CH_CAPT));
        w_lost_nxt  = i_stop ? 1'b0 : w_lost_c;
        w_ovr_nxt   = i_stop ? 1'b0 : w_ovr_c;

        case (r_state)
            CH_IDLE: begin
                if (w_start && i_enable) begin
                    w_state_nxt = CH_CAPT;
                    w_pos_nxt   = i_poscnt;
                end
            end
            CH_CAPT: begin
                if (i_stop) begin
                    if (r_den) begin
                        w_state_nxt = CH_WAIT_LOW;
                    end else if (w_dt_nz) begin
                        w_state_nxt = CH_DEAD;
                        w_dt_nxt    = i_deadtime;
                    end else begin
                        w_state_nxt = CH_IDLE;
                    end
                end
            end
            CH_WAIT_LOW: begin
                if (!r_den) begin
                    if (w_dt_nz) begin
                        w_state_nxt = CH_DEAD;
                        w_dt_nxt    = i_deadtime;
                    end else begin
                        w_state_nxt = CH_IDLE;
                    end
                end
            end
            CH_DEAD: begin
                if (r_dt <= DTW'(1)) begin
                    w_state_nxt = CH_IDLE;
                end else begin
                    w_dt_nxt = r_dt - DTW'(1);
                end
            end
            default: begin
                w_state_nxt = CH_IDLE;
            end
        endcase
    end

    assign o_report_c.hit     = (r_state == CH_CAPT);
    assign o_report_c.lost    = w_lost_c;
    assign o_report_c.overrun = w_ovr_c;
    assign o_pos              = r_pos;

endmodule

// File: rtl/trigger_in_sampler_mc.sv
// Multi-channel 400 MHz trigger sampler: clk80 phase tracking, position counter and per-window report.
module trigger_in_sampler_mc
    import trigger_pkg::*;
#(
    parameter int unsigned NCH  = NCH_DEF,
    parameter int unsigned FILT = FILT_DEF,
    parameter int unsigned POSW = POSW_DEF,
    parameter int unsigned DTW  = DTW_DEF
) (
    input  logic                 clk400,
    input  logic                 reset,
    input  logic                 clk80,
    input  logic                 sync,
    input  logic [NCH-1:0]       enable,
    input  logic [DTW-1:0]       deadtime,
    input  logic [NCH-1:0]       trigger_in,
    output logic                 trig_valid,
    output logic [NCH-1:0]       trig_hit,
    output logic [NCH*POSW-1:0]  trig_pos,
    output logic [NCH-1:0]       trig_lost,
    output logic [NCH-1:0]       trig_overrun
);

    logic                 r_c80_d;
    logic                 r_clear;
    logic                 r_stop;
    logic [POSW-1:0]      r_poscnt;

    logic                 r_valid;
    logic [NCH-1:0]       r_hit;
    logic [NCH*POSW-1:0]  r_pos;
    logic [NCH-1:0]       r_lost;
    logic [NCH-1:0]       r_ovr;

    ch_report_t           w_rep [NCH];
    logic [POSW-1:0]      w_pos [NCH];

    // clk80 is sampled as data; clear marks the first clk400 edge of a sync-qualified clk80 high.
    always_ff @(posedge clk400 or posedge reset) begin
        if (reset) begin
            r_c80_d  <= 1'b0;
            r_clear  <= 1'b0;
            r_stop   <= 1'b0;
            r_poscnt <= '0;
        end else begin
            r_c80_d  <= clk80;
            r_clear  <= sync & clk80 & ~r_c80_d;
            r_stop   <= r_clear;
            r_poscnt <= r_clear ? '0 : r_poscnt + POSW'(1);
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        trigger_in_channel #(
            .FILT (FILT),
            .POSW (POSW),
            .DTW  (DTW)
        ) u_ch (
            .clk400     (clk400),
            .reset      (reset),
            .i_trigger  (trigger_in[gi]),
            .i_enable   (enable[gi]),
            .i_deadtime (deadtime),
            .i_poscnt   (r_poscnt),
            .i_stop     (r_stop),
            .o_report_c (w_rep[gi]),
            .o_pos      (w_pos[gi])
        );
    end

    // Report registers update only on stop; position is kept from the last hit.
    always_ff @(posedge clk400 or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_hit   <= '0;
            r_pos   <= '0;
            r_lost  <= '0;
            r_ovr   <= '0;
        end else begin
            r_valid <= r_stop;
            if (r_stop) begin
                for (int i = 0; i < int'(NCH); i++) begin
                    r_hit[i]  <= w_rep[i].hit;
                    r_lost[i] <= w_rep[i].lost;
                    r_ovr[i]  <= w_rep[i].overrun;
                    if (w_rep[i].hit) begin
                        r_pos[i*POSW +: POSW] <= w_pos[i];
                    end
                end
            end
        end
    end

    assign trig_valid   = r_valid;
    assign trig_hit     = r_hit;
    assign trig_pos     = r_pos;
    assign trig_lost    = r_lost;
    assign trig_overrun = r_ovr;

endmodule

// File: tb/tb_trigger_in_sampler_mc.sv
// Scoreboard bench for trigger_in_sampler_mc: directed trigger schedule, one expected report per sync window.
`timescale 1ns/1ps
module tb_trigger_in_sampler_mc;

    localparam int unsigned NCH  = 4;
    localparam int unsigned FILT = 4;
    localparam int unsigned POSW = 4;
    localparam int unsigned DTW  = 8;
    localparam int NCYC    = 300;
    localparam int END_CYC = 265;

    typedef struct {
        int         cyc;
        logic [3:0] hit;
        logic [15:0] pos;
        logic [3:0] lost;
        logic [3:0] ovr;
    } exp_t;

    logic                clk400 = 1'b0;
    logic                reset;
    logic                clk80;
    logic                sync;
    logic [NCH-1:0]      enable;
    logic [DTW-1:0]      deadtime;
    logic [NCH-1:0]      trigger_in;
    logic                trig_valid;
    logic [NCH-1:0]      trig_hit;
    logic [NCH*POSW-1:0] trig_pos;
    logic [NCH-1:0]      trig_lost;
    logic [NCH-1:0]      trig_overrun;

    logic [3:0] sched [NCYC];
    exp_t       exp_q [$];
    int         cyc = -1;
    int         checks = 0;
    int         errors = 0;
    bit         prev_valid = 1'b0;

    trigger_in_sampler_mc #(
        .NCH  (NCH),
        .FILT (FILT),
        .POSW (POSW),
        .DTW  (DTW)
    ) dut (
        .clk400       (clk400),
        .reset        (reset),
        .clk80        (clk80),
        .sync         (sync),
        .enable       (enable),
        .deadtime     (deadtime),
        .trigger_in   (trigger_in),
        .trig_valid   (trig_valid),
        .trig_hit     (trig_hit),
        .trig_pos     (trig_pos),
        .trig_lost    (trig_lost),
        .trig_overrun (trig_overrun)
    );

    always #1 clk400 = ~clk400;

    always @(posedge clk400) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, got, want);
        end
    endtask

    // Inputs for posedge k: clk80 period of 5 cycles, sync on every fifth clk80.
    task automatic apply(input int k);
        reset      = (k < 3) || (k >= 237 && k <= 240);
        clk80      = (k % 5) < 3;
        sync       = (k % 25) < 3;
        enable     = (k >= 176 && k <= 225) ? 4'b0111 : 4'b1111;
        deadtime   = 8'd20;
        trigger_in = (k < NCYC) ? sched[k] : 4'b0000;
    endtask

    task automatic pulse(input int ch, input int k0, input int len);
        for (int k = k0; k < k0 + len; k++) sched[k][ch] = 1'b1;
    endtask

    task automatic expect_rep(input int c, input logic [3:0] h, input logic [15:0] p,
                              input logic [3:0] l, input logic [3:0] o);
        exp_t e;
        e.cyc = c; e.hit = h; e.pos = p; e.lost = l; e.ovr = o;
        exp_q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},   32'(trig_valid),   32'd0);
        check({tag, "_hit"},     32'(trig_hit),     32'd0);
        check({tag, "_pos"},     32'(trig_pos),     32'd0);
        check({tag, "_lost"},    32'(trig_lost),    32'd0);
        check({tag, "_overrun"}, 32'(trig_overrun), 32'd0);
    endtask

    always @(negedge clk400) apply(cyc + 1);

    // Monitor: every trig_valid pops one expected report.
    always @(negedge clk400) begin
        exp_t e;
        if (prev_valid) check("valid_one_cycle", 32'(trig_valid), 32'd0);
        prev_valid = (trig_valid === 1'b1);
        if (trig_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_report", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("report_cycle", 32'(cyc),          32'(e.cyc));
                check("hit",          32'(trig_hit),     32'(e.hit));
                check("pos",          32'(trig_pos),     32'(e.pos));
                check("lost",         32'(trig_lost),    32'(e.lost));
                check("overrun",      32'(trig_overrun), 32'(e.ovr));
            end
        end
    end

    initial begin
        for (int k = 0; k < NCYC; k++) sched[k] = 4'b0000;
        pulse(0, 26, 12);
        pulse(1, 55, 1);
        pulse(1, 60, 1);
        pulse(1, 62, 1);
        pulse(2, 85, 8);
        pulse(2, 100, 8);
        pulse(3, 126, 8);
        pulse(3, 142, 8);
        for (int ch = 0; ch < 4; ch++) pulse(ch, 180, 8);
        pulse(0, 226, 12);

        expect_rep( 27, 4'b0000, 16'h0000, 4'b0000, 4'b0000);
        expect_rep( 52, 4'b0001, 16'h0006, 4'b0000, 4'b0000);
        expect_rep( 77, 4'b0000, 16'h0006, 4'b0000, 4'b0000);
        expect_rep(102, 4'b0100, 16'h0F06, 4'b0000, 4'b0000);
        expect_rep(127, 4'b0000, 16'h0F06, 4'b0100, 4'b0000);
        expect_rep(152, 4'b1000, 16'h6F06, 4'b0000, 4'b1000);
        expect_rep(177, 4'b0000, 16'h6F06, 4'b0000, 4'b0000);
        expect_rep(202, 4'b0111, 16'h6AAA, 4'b0000, 4'b0000);
        expect_rep(227, 4'b0000, 16'h6AAA, 4'b0000, 4'b0000);
        expect_rep(252, 4'b0000, 16'h0000, 4'b0000, 4'b0000);

        apply(0);
        #0.5;
        check_all_zero("por");

        while (cyc < 236) @(negedge clk400);
        #0.2;
        check_all_zero("midwin_reset");

        while (cyc < END_CYC) @(negedge clk400);
        check("reports_pending", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
